qam_demapper_param: RTL

Parametrised hard-decision QAM demapper with integrated output buffering. It accepts signed I/Q symbol pairs through a valid/ready handshake and slices each pair into Gray-coded bits under a per-symbol modulation mode (QPSK, 16QAM, 64QAM). Demapped words go into an internal show-ahead FIFO, which drains through a second valid/ready handshake. The block replaces the fixed 8-bit 16QAM datapath-plus-FIFO arrangement with a single-clock, width- and depth-configurable unit.

---
 rtl/qam_demapper_param.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/qam_demapper_param.sv
`default_nettype none
// ============================================================================
//  Module   : qam_demapper_param
//  Purpose  : Hard-decision Gray QAM demapper (QPSK / 16QAM / 64QAM, chosen
//             per symbol) followed by a show-ahead FIFO. One symbol clock.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    IN_W   : I/Q sample width, signed two's complement (>= 4)
//    DEPTH  : FIFO entries, power of two (>= 2)
//  Ports
//    sclk        in   symbol clock, rising edge
//    reset       in   synchronous active-high reset
//    mode[1:0]   in   00 QPSK, 01 16QAM, 10 64QAM, 11 decoded as 16QAM
//    I_in, Q_in  in   signed samples
//    in_valid    in   / in_ready out  : input handshake
//    data_out    out  demapped word, zero while out_valid is low
//    out_valid   out  / out_ready in  : output handshake (FIFO head)
//    fill_count  out  FIFO occupancy
//    overflow    out  sticky: a symbol was offered while in_ready was low
//  Build option
//    QAM_DEMAP_64QAM_EN : when defined, mode 10 performs 64QAM slicing;
//                         otherwise modes 10/11 decode as 16QAM and
//                         data_out[5:4] is always 0.
// ============================================================================
module qam_demapper_param #(
  parameter int IN_W  = 8,
  parameter int DEPTH = 16
) (
  input  logic                           sclk,
  input  logic                           reset,
  input  logic [1:0]                     mode,
  input  logic signed [IN_W-1:0]         I_in,
  input  logic signed [IN_W-1:0]         Q_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [5:0]                     data_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     fill_count,
  output logic                           overflow
);

  localparam int AW    = IN_W - 1;          // magnitude width
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Decision thresholds on the folded magnitude, with A = 2^(IN_W-1).
  localparam logic [AW-1:0]    C_HALF  = AW'(1) << (AW - 1);     // A/2
  localparam logic [CNT_W:0]   C_DEPTH = (CNT_W + 1)'(DEPTH);

`ifdef QAM_DEMAP_64QAM_EN
  localparam logic [AW-1:0]    C_QTR   = AW'(1) << (AW - 2);     // A/4
  localparam logic [AW-1:0]    C_3QTR  = C_HALF + C_QTR;         // 3A/4
`endif

  // --------------------------------------------------------------------------
  // Stage 1 register
  // --------------------------------------------------------------------------
  logic [IN_W-1:0] i_q, q_q;
  logic [1:0]      mode_q;
  logic            s1_valid_q;
  logic            overflow_q;

  // --------------------------------------------------------------------------
  // FIFO state
  // --------------------------------------------------------------------------
  logic [5:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             w_accept;
  logic             w_wr;
  logic             w_rd;
  logic [CNT_W:0]   w_occ;
  logic [5:0]       w_word;

  // Folding negative values with ~x keeps the magnitude within IN_W-1 bits,
  // so the most negative input maps to the largest magnitude, not overflow.
  function automatic logic [AW-1:0] fold_mag(input logic [IN_W-1:0] x);
    return x[IN_W-1] ? ~x[AW-1:0] : x[AW-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Flow control. Occupancy counts the word still in stage 1 so that the
  // FIFO can never overflow; out_ready deliberately does not feed in_ready.
  // --------------------------------------------------------------------------
  assign w_occ    = {1'b0, count_q} + {{CNT_W{1'b0}}, s1_valid_q};
  assign in_ready = !reset && (w_occ < C_DEPTH);
  assign w_accept = in_valid && in_ready;

  assign out_valid  = (count_q != '0);
  assign w_wr       = s1_valid_q;
  assign w_rd       = out_valid && out_ready;
  assign data_out   = out_valid ? mem_q[rd_ptr_q] : 6'd0;
  assign fill_count = count_q;
  assign overflow   = overflow_q;

  // --------------------------------------------------------------------------
  // Slicer
  // --------------------------------------------------------------------------
  logic [AW-1:0] w_i_mag, w_q_mag;
  logic          w_i_pos, w_q_pos;
  logic          w_i_lo,  w_q_lo;

  assign w_i_mag = fold_mag(i_q);
  assign w_q_mag = fold_mag(q_q);
  assign w_i_pos = ~i_q[IN_W-1];
  assign w_q_pos = ~q_q[IN_W-1];
  assign w_i_lo  = (w_i_mag < C_HALF);
  assign w_q_lo  = (w_q_mag < C_HALF);

`ifdef QAM_DEMAP_64QAM_EN
  logic w_i_mid, w_q_mid;
  // Third Gray bit: set for the two middle rings of each half-axis.
  assign w_i_mid = (w_i_mag >= C_QTR) && (w_i_mag < C_3QTR);
  assign w_q_mid = (w_q_mag >= C_QTR) && (w_q_mag < C_3QTR);
`endif

  always_comb begin
    w_word = 6'd0;
    case (mode_q)
      2'b00:   w_word[1:0] = {w_i_pos, w_q_pos};
`ifdef QAM_DEMAP_64QAM_EN
      2'b10:   w_word      = {w_i_pos, w_i_lo, w_i_mid, w_q_pos, w_q_lo, w_q_mid};
`endif
      default: w_word[3:0] = {w_i_pos, w_i_lo, w_q_pos, w_q_lo};
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO next-state
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_wr, w_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control and stage-1 registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sclk) begin
    if (reset) begin
      i_q        <= '0;
      q_q        <= '0;
      mode_q     <= 2'b00;
      s1_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= w_accept;
      if (w_accept) begin
        i_q    <= I_in;
        q_q    <= Q_in;
        mode_q <= mode;
      end
      if (in_valid && !in_ready) begin
        overflow_q <= 1'b1;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: stale entries are never visible because
  // data_out is gated by the occupancy count.
  always_ff @(posedge sclk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= w_word;
    end
  end

endmodule
`default_nettype wire
